// File: rtl/cache_lru_ctrl.sv
// rtl/cache_lru_ctrl.sv - per-set true-LRU replacement tracker reporting the eviction victim of a set
module cache_lru_ctrl #(
  parameter int NUM_SET      = 2,
  parameter int NUM_WAYS     = 4,
  parameter int WAYS_PER_SET = 2,
  localparam int SW = (NUM_SET > 1) ? $clog2(NUM_SET) : 1,
  localparam int WW = (WAYS_PER_SET > 1) ? $clog2(WAYS_PER_SET) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          victim_req,
  input  logic [SW-1:0] victim_set,
  output logic [WW-1:0] victim_way,
  input  logic          update_req,
  input  logic [SW-1:0] update_set,
  input  logic [WW-1:0] update_way
);

  // One age per line, grouped by set; 0 is most recent, WAYS_PER_SET-1 is the victim.
  // NUM_WAYS is implied by the two dimensions below.
  logic [WW-1:0] age_q [NUM_SET][WAYS_PER_SET];
  logic [WW-1:0] age_d [NUM_SET][WAYS_PER_SET];

  logic [WW-1:0] touched_age;
  logic [WW-1:0] best_age;
  logic [WW-1:0] best_way;
  logic          update_ok;

  // The query qualifier only matters to the surrounding cache, never to the ordering.
  logic victim_req_unused;
  assign victim_req_unused = victim_req;

  assign update_ok = update_req
                   && (int'(update_set) < NUM_SET)
                   && (int'(update_way) < WAYS_PER_SET);

  // Victim search: oldest way of the queried set, lowest index wins if ages ever tie.
  always_comb begin
    best_age = '0;
    best_way = '0;
    for (int s = 0; s < NUM_SET; s++) begin
      if (s == int'(victim_set)) begin
        best_age = age_q[s][0];
        for (int w = 1; w < WAYS_PER_SET; w++) begin
          if (age_q[s][w] > best_age) begin
            best_age = age_q[s][w];
            best_way = WW'(w);
          end
        end
      end
    end
  end

  assign victim_way = best_way;

  // Next ordering: touched way becomes MRU, ways younger than it age by one.
  always_comb begin
    age_d       = age_q;
    touched_age = '0;
    if (update_ok) begin
      for (int s = 0; s < NUM_SET; s++) begin
        if (s == int'(update_set)) begin
          for (int w = 0; w < WAYS_PER_SET; w++) begin
            if (w == int'(update_way)) begin
              touched_age = age_q[s][w];
            end
          end
          for (int w = 0; w < WAYS_PER_SET; w++) begin
            if (w == int'(update_way)) begin
              age_d[s][w] = '0;
            end else if (age_q[s][w] < touched_age) begin
              age_d[s][w] = age_q[s][w] + WW'(1);
            end
          end
        end
      end
    end
  end

  // Age registers; reset orders each set so way 0 is evicted first, then way 1, and so on.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < NUM_SET; s++) begin
        for (int w = 0; w < WAYS_PER_SET; w++) begin
          age_q[s][w] <= WW'(WAYS_PER_SET - 1 - w);
        end
      end
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: tb/tb_cache_lru_ctrl.sv
// tb/tb_cache_lru_ctrl.sv - scoreboard bench for cache_lru_ctrl with a recency-list reference model
module tb_cache_lru_ctrl;

  localparam int NS  = 2;
  localparam int WPS = 4;
  localparam int NW  = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       victim_req;
  logic [0:0] victim_set;
  logic [1:0] victim_way;
  logic       update_req;
  logic [0:0] update_set;
  logic [1:0] update_way;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected victims, pushed when a cycle is driven and popped when sampled.
  int exp_q[$];

  // Reference model: per set, list of ways ordered most-recent first.
  int order [NS][$];

  cache_lru_ctrl #(
    .NUM_SET      (NS),
    .NUM_WAYS     (NW),
    .WAYS_PER_SET (WPS)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .victim_req (victim_req),
    .victim_set (victim_set),
    .victim_way (victim_way),
    .update_req (update_req),
    .update_set (update_set),
    .update_way (update_way)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      order[s].delete();
      for (int w = WPS - 1; w >= 0; w--) order[s].push_back(w);
    end
  endtask

  task automatic model_touch(input int s, input int w);
    for (int i = 0; i < order[s].size(); i++) begin
      if (order[s][i] == w) begin
        order[s].delete(i);
        break;
      end
    end
    order[s].push_front(w);
  endtask

  function automatic int model_victim(input int s);
    return order[s][order[s].size() - 1];
  endfunction

  // One clock cycle: drive, queue expectation, sample mid-cycle, then advance the model.
  task automatic cycle(input string tag, input int vs, input bit ureq, input int us,
                       input int uw, input bit rst, input int exp_const);
    int got;
    @(posedge clock);
    #1;
    reset      = rst;
    update_req = ureq;
    update_set = 1'(us);
    update_way = 2'(uw);
    victim_set = 1'(vs);
    victim_req = 1'b1;
    exp_q.push_back(model_victim(vs));
    @(negedge clock);
    got = int'(victim_way);
    check_eq(tag, got, exp_q.pop_front());
    if (exp_const >= 0) check_eq({tag, "_plan"}, got, exp_const);
    if (rst) model_reset();
    else if (ureq) model_touch(us, uw);
  endtask

  initial begin
    reset      = 1'b1;
    victim_req = 1'b0;
    victim_set = '0;
    update_req = 1'b0;
    update_set = '0;
    update_way = '0;
    model_reset();
    repeat (2) @(posedge clock);

    // 1: reset ordering, both sets report way 0
    cycle("rst_hold_s0", 0, 0, 0, 0, 1, 0);
    cycle("rst_s0",      0, 0, 0, 0, 0, 0);
    cycle("rst_s1",      1, 0, 0, 0, 0, 0);

    // 2: touch set 0 way 0
    cycle("upd_s0w0_same", 0, 1, 0, 0, 0, 0);
    cycle("after_s0w0_s0", 0, 0, 0, 0, 0, 1);
    cycle("after_s0w0_s1", 1, 0, 0, 0, 0, 0);

    // 3: ways 1,2,3 back to back, then way 0
    cycle("b2b_w1", 0, 1, 0, 1, 0, 1);
    cycle("b2b_w2", 0, 1, 0, 2, 0, -1);
    cycle("b2b_w3", 0, 1, 0, 3, 0, -1);
    cycle("b2b_done", 0, 0, 0, 0, 0, 0);
    cycle("retouch_w0", 0, 1, 0, 0, 0, 0);
    cycle("after_w0", 0, 0, 0, 0, 0, 1);

    // 4: touching the MRU way again changes nothing
    cycle("mru_w3_a", 0, 1, 0, 3, 0, 1);
    cycle("mru_w3_b", 0, 1, 0, 3, 0, 1);
    cycle("mru_after", 0, 0, 0, 0, 0, 1);

    // 5: same-cycle query sees pre-update order
    cycle("nobypass_same", 1, 1, 1, 0, 0, 0);
    cycle("nobypass_next", 1, 0, 0, 0, 0, 1);

    // 6: reset wins over a concurrent update
    cycle("pre_rst_a", 0, 1, 1, 2, 0, -1);
    cycle("pre_rst_b", 1, 1, 0, 1, 0, -1);
    cycle("rst_upd",   0, 1, 0, 0, 1, -1);
    cycle("post_rst_s0", 0, 0, 0, 0, 0, 0);
    cycle("post_rst_s1", 1, 0, 0, 0, 0, 0);

    // Random traffic against the model, with occasional resets
    for (int i = 0; i < 300; i++) begin
      cycle("rand", int'($urandom_range(0, NS - 1)), 1'($urandom_range(0, 3) != 0),
            int'($urandom_range(0, NS - 1)), int'($urandom_range(0, WPS - 1)),
            ($urandom_range(0, 39) == 0), -1);
    end

    check_eq("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
